// File: rtl/block_encoder.sv
// Serial linear block encoder: collects K input bits into a data word, encodes it
// through generator matrix G (or bypasses it), applies the INV mask, and
// re-serialises the N-bit codeword with first/last framing.
module block_encoder #(
  parameter int unsigned K = 4,
  parameter int unsigned N = 8,
  parameter logic [N*K-1:0] G = 32'h7EDB8421,
  parameter logic [N-1:0] INV = '0
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        abort,
  input  logic        mode,
  input  logic        in_valid,
  input  logic        in_bit,
  output logic        in_ready,
  output logic        out_valid,
  output logic        out_bit,
  output logic        out_first,
  output logic        out_last,
  input  logic        out_ready,
  output logic [15:0] words_out
);

  localparam int unsigned InCntW  = $clog2(K);
  localparam int unsigned OutCntW = $clog2(N);
  localparam logic [InCntW-1:0]  InCntMax  = InCntW'(K - 1);
  localparam logic [OutCntW-1:0] OutCntMax = OutCntW'(N - 1);

  typedef enum logic [0:0] {StEmpty, StBusy} state_e;

  state_e              state_q, state_d;
  logic [K-2:0]        coll_q, coll_d;
  logic [InCntW-1:0]   in_cnt_q, in_cnt_d;
  logic [OutCntW-1:0]  out_cnt_q, out_cnt_d;
  logic [N-1:0]        cw_q, cw_d;
  logic [15:0]         words_q, words_d;

  logic         busy;
  logic         accept;
  logic         load;
  logic         xfer;
  logic         done;
  logic [K-1:0] data;
  logic [N-1:0] enc;
  logic [N-1:0] cw_new;

  assign busy      = (state_q == StBusy);
  assign out_valid = busy;
  assign out_first = busy & (out_cnt_q == '0);
  assign out_last  = busy & (out_cnt_q == OutCntMax);
  assign out_bit   = busy & cw_q[out_cnt_q];
  assign words_out = words_q;

  // A complete word may enter only if the output register is free or frees this cycle.
  assign in_ready = (in_cnt_q != InCntMax) | ~busy | (out_last & out_ready);

  assign accept = in_valid & in_ready & ~abort;
  assign load   = accept & (in_cnt_q == InCntMax);
  assign xfer   = out_valid & out_ready & ~abort;
  assign done   = xfer & out_last;

  // Newest bit enters at the MSB so the first accepted bit ends up as d[0].
  assign data = {in_bit, coll_q};

  // Mod-2 product of the data word with each generator row, then mode select and mask.
  always_comb begin
    enc = '0;
    for (int j = 0; j < int'(N); j++) begin
      enc[j] = ^(data & G[j*K +: K]);
    end
    cw_new = (mode ? N'(data) : enc) ^ INV;
  end

  // Next-state logic for collector, output register and counters; abort wins.
  always_comb begin
    state_d   = state_q;
    coll_d    = coll_q;
    in_cnt_d  = in_cnt_q;
    out_cnt_d = out_cnt_q;
    cw_d      = cw_q;
    words_d   = words_q;
    if (abort) begin
      in_cnt_d  = '0;
      out_cnt_d = '0;
      state_d   = StEmpty;
    end else begin
      if (accept) begin
        coll_d   = data[K-1:1];
        in_cnt_d = load ? '0 : in_cnt_q + InCntW'(1);
      end
      if (done) begin
        words_d = words_q + 16'd1;
      end
      if (load) begin
        cw_d      = cw_new;
        state_d   = StBusy;
        out_cnt_d = '0;
      end else if (xfer) begin
        if (out_last) begin
          state_d   = StEmpty;
          out_cnt_d = '0;
        end else begin
          out_cnt_d = out_cnt_q + OutCntW'(1);
        end
      end
    end
  end

  // State registers with asynchronous active-low clear.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q   <= StEmpty;
      coll_q    <= '0;
      in_cnt_q  <= '0;
      out_cnt_q <= '0;
      cw_q      <= '0;
      words_q   <= '0;
    end else begin
      state_q   <= state_d;
      coll_q    <= coll_d;
      in_cnt_q  <= in_cnt_d;
      out_cnt_q <= out_cnt_d;
      cw_q      <= cw_d;
      words_q   <= words_d;
    end
  end

endmodule

// File: doc/block_encoder.md
# block_encoder

Parametrised serial linear block encoder for the OFDM transmit chain. It accepts a bit-serial stream with a valid/ready handshake and groups it into K-bit data words. Each word is encoded into an N-bit codeword through a generator matrix and an output inversion mask, and the codeword is re-serialised with valid/ready plus word framing flags. The next data word is collected while the current codeword drains; the block sits between the scrambler/bit source and the interleaver/mapper.

## Interface
- K, 4, data bits per word (2..16)
- N, 8, code bits per word (K..32)
- G, 32'h7EDB8421, N*K-bit generator; row j = G[j*K +: K], code bit c[j] = XOR-reduce(d & row j); default = systematic extended Hamming(8,4)
- INV, 0, N-bit mask XORed onto the codeword (bit j inverts c[j])
- clk  in  1  clock, all state on rising edge
- reset  in  1  asynchronous, active-low; clears all state
- abort  in  1  synchronous discard of partial input word and any buffered/draining codeword
- mode  in  1  0 = encode; 1 = bypass (c = {N-K zeros, d}, INV still applied); sampled with the K-th input bit
- in_valid  in  1  input bit valid
- in_bit  in  1  input data bit; first accepted bit of a word is d[0]
- in_ready  out  1  block can accept in_bit this cycle
- out_valid  out  1  out_bit valid
- out_bit  out  1  code bit; c[0] first, c[N-1] last
- out_first  out  1  high with c[0]
- out_last  out  1  high with c[N-1]
- out_ready  in  1  sink accepts out_bit this cycle
- words_out  out  16  count of fully transferred codewords, wraps at 65535->0

## Operation
- Input accept = in_valid & in_ready. Accepts shift into a K-bit collector; in_cnt counts 0..K-1.
- On an accept with in_cnt == K-1, the codeword is formed combinationally from {in_bit, collected bits} and current mode, then loaded into the N-bit output register; in_cnt returns to 0.
- Output register states: EMPTY and BUSY. EMPTY->BUSY on load. BUSY->EMPTY when the bit with out_cnt == N-1 is transferred (out_valid & out_ready) with no simultaneous load. Same-cycle drain and load stays BUSY with the new word, out_cnt = 0.
- in_ready = (in_cnt != K-1) | EMPTY | (out_last & out_ready). This is a combinational path from out_ready; no other combinational input->output paths exist.
- Output transfer advances out_cnt. out_bit = codeword[out_cnt]. out_valid = BUSY.
- words_out increments on every transfer with out_last.
- abort: in_cnt <- 0, output -> EMPTY, out_cnt <- 0, and the in-flight input accept is dropped. words_out is not cleared. abort has priority over all other events that cycle.
- Encoding is mod-2 only: AND plus XOR-reduce per row. There is no arithmetic carry.

## Timing
- Reset values: in_ready 1, out_valid 0, out_bit 0, out_first 0, out_last 0, words_out 0, in_cnt 0, out_cnt 0, state EMPTY.
- Latency: K-th bit accepted at edge t gives out_valid = 1 with c[0] in the cycle after t.
- Steady-state throughput with out_ready held high: one codeword per N cycles. The input is stalled (in_ready = 0) only while the next word is complete and the previous codeword has not drained. No bubble appears between consecutive codewords.
- out_bit, out_first and out_last are held stable while out_valid & !out_ready.
- Reset asserted mid-word or mid-codeword: all outputs return to reset values immediately (asynchronous); the partial word is lost.

## Test plan
- Default params, mode 0, feed d0..d3 = 1,1,0,1 with out_ready = 1 -> out_bit sequence 1,1,0,1,1,0,0,0; out_first on the 1st bit, out_last on the 8th; words_out = 1; out_valid in the cycle after the 4th accept.
- Back-to-back words 0000 and 1111 with continuous in_valid and out_ready -> codewords 00000000 then 11111111 (c4..c7 = 1,1,1,1); the second follows with no gap; in_ready low for exactly 4 cycles while the first drains.
- out_ready low for 5 cycles mid-codeword -> out_bit, out_first and out_last are frozen; after release the remaining bits arrive in order; a third word completing during the stall sees in_ready = 0 until out_last & out_ready.
- mode 1 with INV = 8'h80, data 1,0,1,1 -> out 1,0,1,1,0,0,0,1.
- abort asserted after 2 input bits and during the 3rd output bit of the previous word -> out_valid = 0 on the next cycle; the next 4 bits form a fresh word; words_out is unchanged.
- reset asserted asynchronously mid-stream -> all outputs reach reset values before the next clock edge; words_out = 0; the first word after reset encodes correctly.
